// File: rtl/fb_rect_writer.sv
// fb_rect_writer: rectangle fill engine feeding the frame-buffer write port.
// Takes one command over a valid/ready handshake. It then writes one pixel per
// clock in raster order at address x + y*SCREEN_X.
// Optional feature: define FB_RECT_CLIP_EN to clip rectangles to the screen.
// Without it, out-of-bounds rectangles are rejected with a one-cycle err pulse.
module fb_rect_writer #(
  parameter int unsigned SCREEN_X = 640,
  parameter int unsigned SCREEN_Y = 480,
  parameter int unsigned AW       = 19,
  parameter int unsigned DW       = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [9:0]    cmd_x0,
  input  logic [8:0]    cmd_y0,
  input  logic [9:0]    cmd_w,
  input  logic [8:0]    cmd_h,
  input  logic [DW-1:0] cmd_color,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

  localparam logic [10:0]   X_LIM  = 11'(SCREEN_X);
  localparam logic [10:0]   Y_LIM  = 11'(SCREEN_Y);
  localparam logic [AW-1:0] STRIDE = AW'(SCREEN_X);

  state_t state_q, state_d;

  // Latched command fields.
  logic [9:0]    x0_q, w_q;
  logic [8:0]    y0_q, h_q;
  logic [DW-1:0] color_q;

  // Raster walk state.
  logic [AW-1:0] row_base_q, row_base_d;
  logic [9:0]    xcnt_q, xcnt_d, w_eff_q, w_eff_d;
  logic [8:0]    ycnt_q, ycnt_d, h_eff_q, h_eff_d;

  // Values derived from the latched command during SETUP.
  logic [10:0]   x_end, y_end;
  logic [9:0]    w_setup;
  logic [8:0]    h_setup;
  logic [AW-1:0] base_setup;
  logic          reject;

  // Next values of the registered outputs.
  logic          px_wr_d, done_d, err_d;
  logic [AW-1:0] addr_d;

  logic accept;
  assign accept = cmd_valid && cmd_ready;

  // Geometry: end coordinates, effective size, first-row base address.
  always_comb begin
    x_end      = {1'b0, x0_q} + {1'b0, w_q};
    y_end      = {2'b0, y0_q} + {2'b0, h_q};
    base_setup = AW'(y0_q) * STRIDE + AW'(x0_q);
`ifdef FB_RECT_CLIP_EN
    reject = 1'b0;
    if (({1'b0, x0_q} >= X_LIM) || ({2'b0, y0_q} >= Y_LIM)) begin
      // The origin is off screen, so nothing is visible.
      w_setup = '0;
      h_setup = '0;
    end else begin
      w_setup = 10'(((x_end > X_LIM) ? X_LIM : x_end) - {1'b0, x0_q});
      h_setup = 9'(((y_end > Y_LIM) ? Y_LIM : y_end) - {2'b0, y0_q});
    end
`else
    reject  = (x_end > X_LIM) || (y_end > Y_LIM);
    w_setup = w_q;
    h_setup = h_q;
`endif
  end

  // Next-state logic and next values for the walk counters and outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    state_d    = state_q;
    row_base_d = row_base_q;
    xcnt_d     = xcnt_q;
    ycnt_d     = ycnt_q;
    w_eff_d    = w_eff_q;
    h_eff_d    = h_eff_q;
    px_wr_d    = 1'b0;
    addr_d     = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SETUP;
      end
      SETUP: begin
        w_eff_d    = w_setup;
        h_eff_d    = h_setup;
        row_base_d = base_setup;
        xcnt_d     = '0;
        ycnt_d     = '0;
        if (reject) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if ((w_setup == '0) || (h_setup == '0)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAW;
          px_wr_d = 1'b1;
          addr_d  = base_setup;
        end
      end
      DRAW: begin
        if (xcnt_q == w_eff_q - 10'd1) begin
          if (ycnt_q == h_eff_q - 9'd1) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            xcnt_d     = '0;
            ycnt_d     = ycnt_q + 9'd1;
            row_base_d = row_base_q + STRIDE;
            px_wr_d    = 1'b1;
            addr_d     = row_base_q + STRIDE;
          end
        end else begin
          xcnt_d  = xcnt_q + 10'd1;
          px_wr_d = 1'b1;
          addr_d  = row_base_q + AW'(xcnt_q + 10'd1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= '0;
      row_base_q  <= '0;
      xcnt_q      <= '0;
      ycnt_q      <= '0;
      w_eff_q     <= '0;
      h_eff_q     <= '0;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      px_wr       <= 1'b0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      state_q    <= state_d;
      row_base_q <= row_base_d;
      xcnt_q     <= xcnt_d;
      ycnt_q     <= ycnt_d;
      w_eff_q    <= w_eff_d;
      h_eff_q    <= h_eff_d;
      if (accept) begin
        x0_q    <= cmd_x0;
        y0_q    <= cmd_y0;
        w_q     <= cmd_w;
        h_q     <= cmd_h;
        color_q <= cmd_color;
      end
      cmd_ready   <= (state_d == IDLE);
      busy        <= (state_d != IDLE);
      px_wr       <= px_wr_d;
      mem_px_addr <= addr_d;
      mem_px_data <= px_wr_d ? color_q : '0;
      done        <= done_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed bench for fb_rect_writer. Inputs are driven and outputs are sampled
// on the falling edge. The DUT changes only on the rising edge.
module tb_fb_rect_writer;

  localparam int AW = 19;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [9:0]    cmd_x0 = '0;
  logic [8:0]    cmd_y0 = '0;
  logic [9:0]    cmd_w = '0;
  logic [8:0]    cmd_h = '0;
  logic [DW-1:0] cmd_color = '0;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr, busy, done, err;

  int checks   = 0;
  int failures = 0;
  int unsigned exp_q[$];

  fb_rect_writer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color),
    .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data),
    .px_wr(px_wr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a command, wait (bounded) for it to be taken, then check SETUP.
  task automatic send(input string tag, input int x0, input int y0, input int w,
                      input int h, input logic [DW-1:0] color);
    int n;
    cmd_x0    = 10'(x0);
    cmd_y0    = 9'(y0);
    cmd_w     = 10'(w);
    cmd_h     = 9'(h);
    cmd_color = color;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_ready_wait"}, 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    check({tag, "_setup_ready"}, 32'(cmd_ready), 0);
    check({tag, "_setup_busy"},  32'(busy), 1);
    check({tag, "_setup_wr"},    32'(px_wr), 0);
  endtask

  // Check the write stream listed in exp_q, then the done pulse and return to idle.
  task automatic expect_writes(input string tag, input logic [DW-1:0] color);
    foreach (exp_q[i]) begin
      tick();
      check({tag, "_wr"},   32'(px_wr), 1);
      check({tag, "_addr"}, 32'(mem_px_addr), exp_q[i]);
      check({tag, "_data"}, 32'(mem_px_data), 32'(color));
      check({tag, "_busy"}, 32'(busy), 1);
      check({tag, "_done_early"}, 32'(done), 0);
    end
    tick();
    check({tag, "_done"},       32'(done), 1);
    check({tag, "_done_wr"},    32'(px_wr), 0);
    check({tag, "_done_err"},   32'(err), 0);
    check({tag, "_done_busy"},  32'(busy), 1);
    check({tag, "_done_ready"}, 32'(cmd_ready), 0);
    tick();
    check({tag, "_idle_done"},  32'(done), 0);
    check({tag, "_idle_ready"}, 32'(cmd_ready), 1);
    check({tag, "_idle_busy"},  32'(busy), 0);
  endtask

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 0);
    check("rst_wr",    32'(px_wr), 0);
    check("rst_addr",  32'(mem_px_addr), 0);
    check("rst_data",  32'(mem_px_data), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_err",   32'(err), 0);
    rst = 1'b0;
    #1;
    check("rel_ready_before_clk", 32'(cmd_ready), 0);
    tick();
    check("rel_ready", 32'(cmd_ready), 1);

    // Single pixel at the origin.
    send("px1", 0, 0, 1, 1, 12'hF00);
    exp_q = '{0};
    expect_writes("px1", 12'hF00);

    // 3x2 rectangle at (10,2): rows start at 2*640+10 and 3*640+10.
    send("r3x2", 10, 2, 3, 2, 12'h0F0);
    exp_q = '{1290, 1291, 1292, 1930, 1931, 1932};
    expect_writes("r3x2", 12'h0F0);

    // Bottom-right corner crossing both screen edges.
    send("edge", 638, 479, 4, 3, 12'h00F);
`ifdef FB_RECT_CLIP_EN
    exp_q = '{307198, 307199};
    expect_writes("edge", 12'h00F);
`else
    tick();
    check("edge_err",     32'(err), 1);
    check("edge_done",    32'(done), 0);
    check("edge_wr",      32'(px_wr), 0);
    check("edge_busy",    32'(busy), 1);
    tick();
    check("edge_err_end", 32'(err), 0);
    check("edge_done2",   32'(done), 0);
    check("edge_wr2",     32'(px_wr), 0);
    check("edge_ready",   32'(cmd_ready), 1);
    check("edge_busy2",   32'(busy), 0);
`endif

    // Exactly at the right edge is in bounds in both builds.
    send("fit", 637, 0, 3, 1, 12'h555);
    exp_q = '{637, 638, 639};
    expect_writes("fit", 12'h555);

    // Zero width: done two cycles after acceptance, no writes.
    send("empty", 5, 5, 0, 5, 12'hFFF);
    exp_q.delete();
    expect_writes("empty", 12'hFFF);

    // Back-to-back: a second command is held valid during the first's DRAW.
    send("b2b_a", 0, 1, 2, 1, 12'hABC);
    cmd_x0 = 10'd3; cmd_y0 = 9'd0; cmd_w = 10'd1; cmd_h = 9'd1; cmd_color = 12'h123;
    cmd_valid = 1'b1;
    tick();
    check("b2b_a_wr0",   32'(mem_px_addr), 640);
    tick();
    check("b2b_a_wr1",   32'(mem_px_addr), 641);
    check("b2b_a_data1", 32'(mem_px_data), 12'hABC);
    tick();
    check("b2b_a_done",  32'(done), 1);
    check("b2b_a_noacc", 32'(cmd_ready), 0);
    tick();
    check("b2b_idle_ready", 32'(cmd_ready), 1);
    check("b2b_idle_busy",  32'(busy), 0);
    tick();
    cmd_valid = 1'b0;
    check("b2b_b_setup_ready", 32'(cmd_ready), 0);
    check("b2b_b_setup_busy",  32'(busy), 1);
    check("b2b_b_setup_wr",    32'(px_wr), 0);
    exp_q = '{3};
    expect_writes("b2b_b", 12'h123);

    // Reset in the middle of a 100-pixel fill, at pixel 40.
    send("long", 0, 10, 100, 1, 12'h777);
    repeat (41) tick();
    check("long_px40_wr",   32'(px_wr), 1);
    check("long_px40_addr", 32'(mem_px_addr), 6440);
    rst = 1'b1;
    #1;
    check("mid_rst_wr",    32'(px_wr), 0);
    check("mid_rst_busy",  32'(busy), 0);
    check("mid_rst_done",  32'(done), 0);
    check("mid_rst_ready", 32'(cmd_ready), 0);
    check("mid_rst_addr",  32'(mem_px_addr), 0);
    repeat (2) @(negedge clk);
    check("mid_rst_hold_done", 32'(done), 0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(cmd_ready), 1);
    check("post_rst_done",  32'(done), 0);
    check("post_rst_wr",    32'(px_wr), 0);

    // A fresh command after reset runs normally.
    send("fresh", 1, 1, 2, 2, 12'h0AF);
    exp_q = '{641, 642, 1281, 1282};
    expect_writes("fresh", 12'h0AF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fb_rect_writer.md
# fb_rect_writer

Frame-buffer fill engine that sits directly upstream of the dual-port frame buffer write port, alongside the game FSM. It accepts one rectangle draw command at a time over a valid/ready handshake. It then streams one pixel write per clock into the buffer's write port (address, data, write strobe) in raster order, using linear address x + y*SCREEN_X. The VGA driver reads the same buffer independently on the read port.

## Interface
Parameters:
- SCREEN_X, 640, visible width in pixels; row stride of the buffer
- SCREEN_Y, 480, visible height in pixels
- AW, 19, buffer address width
- DW, 12, pixel width (RGB 444)

Ports:
- clk  in  1  pixel/system clock (same clock as buffer write port)
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_x0  in  10  left column
- cmd_y0  in  9  top row
- cmd_w  in  10  width in pixels
- cmd_h  in  9  height in pixels
- cmd_color  in  DW  fill colour
- mem_px_addr  out  AW  buffer write address
- mem_px_data  out  DW  buffer write data
- px_wr  out  1  buffer write strobe
- busy  out  1  command in progress
- done  out  1  one-cycle pulse: command finished
- err  out  1  one-cycle pulse: command rejected (macro off only)

## Operation
- States: IDLE, SETUP, DRAW, DONE.
- IDLE:
  - cmd_ready=1 and busy=0.
  - On cmd_valid && cmd_ready, latch all cmd_* fields and go to SETUP.
- SETUP (one cycle), with cmd_ready=0 and busy=1:
  - Compute x_end = x0+w and y_end = y0+h, each 11 bits with no overflow.
  - Apply clipping or rejection (see Configuration).
  - Compute row_base = y0*SCREEN_X + x0 at AW bits.
  - If the effective width or height is 0, go to DONE with no writes. Otherwise go to DRAW.
- DRAW: each cycle px_wr=1, mem_px_addr=row_base+xcnt, mem_px_data=color.
  - xcnt increments each cycle.
  - At the last column, reset xcnt to 0 and set row_base += SCREEN_X.
  - After the last pixel of the last row, go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy stays 1 and cmd_ready=0.
  - Next state is IDLE.
- cmd_valid while not in IDLE is ignored and must be held by the source; no queueing.
- Writes are strictly raster order and gap-free: exactly w_eff*h_eff px_wr cycles per command.
- Address never exceeds SCREEN_X*SCREEN_Y-1 for any accepted, non-empty command.

## Timing
- All outputs are registered.
- Reset values: cmd_ready=0 while rst is high, then 1 from the first clock after deassertion. px_wr=0, mem_px_addr=0, mem_px_data=0, busy=0, done=0, err=0.
- Command accepted at edge N:
  - SETUP in cycle N+1.
  - First px_wr in cycle N+2.
  - Last px_wr in cycle N+1+w_eff*h_eff.
  - done in the following cycle.
  - cmd_ready=1 in the cycle after done.
- Empty command: done in cycle N+2; no px_wr.
- Minimum command spacing is therefore 3 + w_eff*h_eff cycles.
- Reset mid-operation: all outputs go to their reset values asynchronously. The in-flight command is discarded and no done is produced.
- done and err are never asserted in the same cycle.

## Configuration
- Macro: FB_RECT_CLIP_EN.
- Defined: rectangles are clipped to the screen.
  - w_eff = min(x_end, SCREEN_X) - x0 and h_eff = min(y_end, SCREEN_Y) - y0.
  - x0>=SCREEN_X or y0>=SCREEN_Y gives an empty command, ending with done and no writes.
  - err is tied to 0.
- Not defined: any command with x_end>SCREEN_X or y_end>SCREEN_Y is rejected.
  - SETUP goes to DONE-equivalent timing with err=1 for one cycle instead of done.
  - No writes occur.
  - In-bounds commands behave identically to the clipped build.

## Test plan
- Reset release, then cmd (x0=0, y0=0, w=1, h=1, color=12'hF00) -> cmd_ready drops the cycle after acceptance. One px_wr with addr=0 and data=F00 two cycles after acceptance, then done 1 cycle later.
- cmd (x0=10, y0=2, w=3, h=2, color=12'h0F0) -> 6 consecutive px_wr at addrs 1290, 1291, 1292, 1930, 1931, 1932, then done; busy high throughout.
- cmd (x0=638, y0=479, w=4, h=3):
  - With FB_RECT_CLIP_EN: 2 writes at 307198 and 307199, then done.
  - Without it: err pulse, zero px_wr, done never asserted.
- cmd w=0, h=5 -> no px_wr; done in acceptance cycle +2.
- Back-to-back: hold cmd_valid high with a second command during DRAW of the first. The second is accepted only the cycle after the first's done, and its writes begin 2 cycles later.
- Assert rst during DRAW of a 100-pixel fill at pixel 40 -> px_wr, busy and done are 0 immediately and no done is produced. After release, cmd_ready=1 and a fresh command executes normally.
